// File: rtl/line_buffer_if.sv
// ---------------------------------------------------------------------------
// line_buffer_if
// Pixel-stream and window-output bundle for the line_buffer sliding-window
// generator.
//   i_in_valid     : pixel qualifier (source -> line_buffer)
//   i_in_pixel     : raster-order pixel value (source -> line_buffer)
//   o_window_valid : one-cycle strobe for o_window / o_if_x / o_if_y
//   o_window       : KX*KY window, element (wy,wx) at [(wy*KX+wx)*I_F_BW +: I_F_BW]
//   o_if_x, o_if_y : window top-left coordinate
//   o_frame_done   : end-of-frame pulse (only with LINE_BUFFER_FRAME_DONE_EN)
// Modports: master = pixel source / window consumer side, slave = line_buffer.
// ---------------------------------------------------------------------------
interface line_buffer_if #(
    parameter int I_F_BW = 8,
    parameter int IX     = 28,
    parameter int IY     = 28,
    parameter int KX     = 5,
    parameter int KY     = 5
);
    logic                       i_in_valid;
    logic [I_F_BW-1:0]          i_in_pixel;
    logic                       o_window_valid;
    logic [KX*KY*I_F_BW-1:0]    o_window;
    logic [$clog2(IX)-1:0]      o_if_x;
    logic [$clog2(IY)-1:0]      o_if_y;
`ifdef LINE_BUFFER_FRAME_DONE_EN
    logic                       o_frame_done;

    modport master (
        output i_in_valid, i_in_pixel,
        input  o_window_valid, o_window, o_if_x, o_if_y, o_frame_done
    );
    modport slave (
        input  i_in_valid, i_in_pixel,
        output o_window_valid, o_window, o_if_x, o_if_y, o_frame_done
    );
`else
    modport master (
        output i_in_valid, i_in_pixel,
        input  o_window_valid, o_window, o_if_x, o_if_y
    );
    modport slave (
        input  i_in_valid, i_in_pixel,
        output o_window_valid, o_window, o_if_x, o_if_y
    );
`endif
endinterface

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// Streaming KX x KY sliding-window generator for the convolution front end.
// Takes one raster-order pixel per valid cycle from an IX x IY feature map and
// emits the complete window (plus its top-left coordinate) one cycle after
// the pixel that completes it is accepted. No backpressure.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous reset, ACTIVE-HIGH despite the name
//   bus     : line_buffer_if.slave (pixel in, window / coordinates out)
// Optional feature macro: LINE_BUFFER_FRAME_DONE_EN adds bus.o_frame_done, a
// one-cycle pulse coincident with the last window of each frame.
// ---------------------------------------------------------------------------
module line_buffer #(
    parameter int I_F_BW = 8,
    parameter int IX     = 28,
    parameter int IY     = 28,
    parameter int KX     = 5,
    parameter int KY     = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    line_buffer_if.slave  bus
);
    localparam int XW = $clog2(IX);
    localparam int YW = $clog2(IY);
    localparam int WW = KX * KY * I_F_BW;

    localparam logic [XW-1:0] X_LAST      = XW'(IX - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(IY - 1);
    localparam logic [XW-1:0] X_FIRST_WIN = XW'(KX - 1);
    localparam logic [YW-1:0] Y_FIRST_WIN = YW'(KY - 1);

    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    // r_lmem[0] is the oldest stored line, r_lmem[KY-2] the line just above
    logic [I_F_BW-1:0] r_lmem [KY-1][IX];
    logic [WW-1:0]     r_win;
    logic [WW-1:0]     r_out_win;
    logic              r_out_vld;
    logic [XW-1:0]     r_out_x;
    logic [YW-1:0]     r_out_y;

    logic [I_F_BW-1:0] w_col [KY];
    logic [WW-1:0]     w_win_next;
    logic              w_accept;
    logic              w_emit;

    assign w_accept = bus.i_in_valid;
    // Only columns x >= KX-1 close a window, so no window spans a line wrap;
    // y >= KY-1 guarantees every row comes from the current frame.
    assign w_emit   = w_accept && (r_x >= X_FIRST_WIN) && (r_y >= Y_FIRST_WIN);

    // New column: stored pixels above the current x, incoming pixel at bottom.
    always_comb begin
        for (int k = 0; k < KY; k++) begin
            w_col[k] = '0;
        end
        for (int k = 0; k < KY - 1; k++) begin
            w_col[k] = r_lmem[k][r_x];
        end
        w_col[KY-1] = bus.i_in_pixel;
    end

    // Shift every window row left by one column and append the new column.
    always_comb begin
        w_win_next = r_win;
        for (int wy = 0; wy < KY; wy++) begin
            for (int wx = 0; wx < KX - 1; wx++) begin
                w_win_next[(wy*KX+wx)*I_F_BW +: I_F_BW] = r_win[(wy*KX+wx+1)*I_F_BW +: I_F_BW];
            end
            w_win_next[(wy*KX+KX-1)*I_F_BW +: I_F_BW] = w_col[wy];
        end
    end

    // Line memories: each column shifts up one line per accepted pixel, so
    // contents are never cleared; stale lines are masked by the y rule.
    always_ff @(posedge clk) begin
        if (w_accept && !reset_n) begin
            for (int k = 0; k < KY - 1; k++) begin
                r_lmem[k][r_x] <= w_col[k+1];
            end
        end
    end

    // Stage boundary: accepted pixel -> registered window outputs.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_win     <= '0;
            r_out_win <= '0;
            r_out_vld <= 1'b0;
            r_out_x   <= '0;
            r_out_y   <= '0;
        end else begin
            r_out_vld <= w_emit;
            if (w_accept) begin
                r_win <= w_win_next;
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
                if (w_emit) begin
                    r_out_win <= w_win_next;
                    r_out_x   <= r_x - X_FIRST_WIN;
                    r_out_y   <= r_y - Y_FIRST_WIN;
                end
            end
        end
    end

    assign bus.o_window_valid = r_out_vld;
    assign bus.o_window       = r_out_win;
    assign bus.o_if_x         = r_out_x;
    assign bus.o_if_y         = r_out_y;

`ifdef LINE_BUFFER_FRAME_DONE_EN
    logic r_frame_done;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && (r_x == X_LAST) && (r_y == Y_LAST);
        end
    end

    assign bus.o_frame_done = r_frame_done;
`endif

endmodule

// File: tb/tb_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_line_buffer
// Self-checking bench for line_buffer. A reference model keeps the current
// frame as a 2-D pixel array and derives every expected window directly from
// it by coordinate arithmetic.
// ---------------------------------------------------------------------------
module tb_line_buffer;
    localparam int I_F_BW = 8;
    localparam int IX     = 28;
    localparam int IY     = 28;
    localparam int KX     = 5;
    localparam int KY     = 5;
    localparam int WW     = KX * KY * I_F_BW;
    localparam int NPIX   = IX * IY;
    localparam int NWIN   = (IX - KX + 1) * (IY - KY + 1);

    typedef struct {
        int            ifx;
        int            ify;
        logic [WW-1:0] win;
        int            cyc;
        int            acc;
    } wrec_t;

    logic clk;
    logic reset_n;

    line_buffer_if #(.I_F_BW(I_F_BW), .IX(IX), .IY(IY), .KX(KX), .KY(KY)) bus ();

    line_buffer #(.I_F_BW(I_F_BW), .IX(IX), .IY(IY), .KX(KX), .KY(KY)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    frame [IY][IX];
    int            m_x, m_y, accepted, cycle;
    logic [WW-1:0] e_win;
    int            e_ifx, e_ify;
    bit            e_vld, e_fd;
    int            fd_cnt;
    wrec_t         cap [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int elem(input logic [WW-1:0] w, input int wy, input int wx);
        return int'(w[(wy*KX+wx)*I_F_BW +: I_F_BW]);
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; accepted = 0; cycle = 0; fd_cnt = 0;
        e_win = '0; e_ifx = 0; e_ify = 0; e_vld = 0; e_fd = 0;
        cap.delete();
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b1;
        bus.i_in_valid = 1'b1;
        bus.i_in_pixel = 8'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_valid", bus.o_window_valid, 0);
            chk("rst_window", bus.o_window, 0);
            chk("rst_if_x", bus.o_if_x, 0);
            chk("rst_if_y", bus.o_if_y, 0);
`ifdef LINE_BUFFER_FRAME_DONE_EN
            chk("rst_frame_done", bus.o_frame_done, 0);
`endif
        end
        reset_n = 1'b0;
        bus.i_in_valid = 1'b0;
        model_reset();
    endtask

    task automatic step(input bit v, input logic [7:0] p);
        wrec_t r;
        bus.i_in_valid = v;
        bus.i_in_pixel = p;
        @(posedge clk);
        e_vld = 0;
        e_fd  = 0;
        if (v) begin
            frame[m_y][m_x] = p;
            accepted++;
            if (m_x >= KX - 1 && m_y >= KY - 1) begin
                e_vld = 1;
                e_ifx = m_x - KX + 1;
                e_ify = m_y - KY + 1;
                for (int wy = 0; wy < KY; wy++)
                    for (int wx = 0; wx < KX; wx++)
                        e_win[(wy*KX+wx)*I_F_BW +: I_F_BW] = frame[e_ify+wy][e_ifx+wx];
            end
            if (m_x == IX - 1 && m_y == IY - 1) e_fd = 1;
            m_x++;
            if (m_x == IX) begin
                m_x = 0;
                m_y++;
                if (m_y == IY) m_y = 0;
            end
        end
        #1;
        chk("window_valid", bus.o_window_valid, e_vld);
        chk("window", bus.o_window, e_win);
        chk("if_x", bus.o_if_x, e_ifx);
        chk("if_y", bus.o_if_y, e_ify);
`ifdef LINE_BUFFER_FRAME_DONE_EN
        chk("frame_done", bus.o_frame_done, e_fd);
        if (bus.o_frame_done) fd_cnt++;
`endif
        if (bus.o_window_valid) begin
            r.ifx = int'(bus.o_if_x);
            r.ify = int'(bus.o_if_y);
            r.win = bus.o_window;
            r.cyc = cycle;
            r.acc = accepted;
            cap.push_back(r);
        end
        cycle++;
    endtask

    initial begin
        reset_n = 1'b1;
        bus.i_in_valid = 1'b0;
        bus.i_in_pixel = '0;
        model_reset();

        // Gap-free frame with pixel value (i+1) mod 256
        do_reset(3);
        for (int i = 0; i < NPIX; i++) step(1'b1, 8'((i + 1) % 256));
        step(1'b0, 8'h00);
        chk("win_count", cap.size(), NWIN);
        if (cap.size() >= NWIN) begin
            chk("first_acc", cap[0].acc, 117);
            chk("first_x", cap[0].ifx, 0);
            chk("first_y", cap[0].ify, 0);
            for (int wy = 0; wy < KY; wy++)
                for (int wx = 0; wx < KX; wx++)
                    chk("first_elem", elem(cap[0].win, wy, wx), wy * IX + wx + 1);
            chk("last_x", cap[NWIN-1].ifx, 23);
            chk("last_y", cap[NWIN-1].ify, 23);
            chk("last_e00", elem(cap[NWIN-1].win, 0, 0), 156);
            chk("last_e44", elem(cap[NWIN-1].win, 4, 4), 16);
            for (int i = 0; i < IX - KX + 1; i++) begin
                chk("row0_x", cap[i].ifx, i);
                chk("row0_y", cap[i].ify, 0);
                chk("row0_consec", cap[i].cyc, cap[0].cyc + i);
            end
        end

        // Same stream with random idle gaps
        do_reset(1);
        for (int i = 0; i < NPIX; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) step(1'b0, 8'($urandom));
            end
            step(1'b1, 8'((i + 1) % 256));
        end
        repeat (2) step(1'b0, 8'h00);
        chk("gap_win_count", cap.size(), NWIN);

        // Random pixels, mid-frame reset at pixel 300, then restart
        do_reset(1);
        for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom));
        do_reset(2);
        for (int i = 0; i < 200; i++) step(1'b1, 8'((i + 1) % 256));
        chk("rst_win_seen", cap.size() > 0, 1);
        if (cap.size() > 0) begin
            chk("rst_first_acc", cap[0].acc, 117);
            chk("rst_first_x", cap[0].ifx, 0);
            chk("rst_first_y", cap[0].ify, 0);
            chk("rst_first_e44", elem(cap[0].win, 4, 4), 117);
        end

`ifdef LINE_BUFFER_FRAME_DONE_EN
        // Two back-to-back frames of random pixels
        do_reset(1);
        for (int i = 0; i < 2 * NPIX; i++) step(1'b1, 8'($urandom));
        step(1'b0, 8'h00);
        chk("fd_count", fd_cnt, 2);
        chk("two_frame_wins", cap.size(), 2 * NWIN);
        if (cap.size() > NWIN) begin
            chk("f2_first_x", cap[NWIN].ifx, 0);
            chk("f2_first_y", cap[NWIN].ify, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_buffer.md
Name: line_buffer

Overview:
- Streaming sliding-window generator for the convolution front end.
- Accepts one raster-order pixel per valid cycle from an IX x IY feature map.
- Emits a full KX x KY window, plus the window's top-left output coordinate, whenever the newest pixel completes a window.
- Sits between the pixel source and the MAC/conv array.

Parameters:
- I_F_BW, 8: pixel bit width.
- IX, 28: input feature map width (pixels per line).
- IY, 28: input feature map height (lines per frame).
- KX, 5: window width; 2 <= KX <= IX.
- KY, 5: window height; 2 <= KY <= IY.

Ports:
- clk  input  1: single clock; all logic on the rising edge.
- reset_n  input  1: synchronous, active-high reset. Reset is asserted when reset_n==1, despite the suffix; the codebase port name is kept.
- i_in_valid  input  1: pixel qualifier. No backpressure; every valid pixel is accepted.
- i_in_pixel  input  I_F_BW: pixel value, raster order (x fastest).
- o_window_valid  output  1: one-cycle strobe marking o_window, o_if_x and o_if_y as valid.
- o_window  output  KX*KY*I_F_BW: element (wy,wx) at bits [(wy*KX+wx)*I_F_BW +: I_F_BW].
  - wy=0 is the oldest (top) row; wx=0 is the leftmost column.
- o_if_x  output  $clog2(IX): window top-left column, 0..IX-KX.
- o_if_y  output  $clog2(IY): window top-left row, 0..IY-KY.

Behaviour:
- Storage:
  - KY-1 line memories, each IX x I_F_BW, holding the previous KY-1 lines.
  - A KY x KX register window shifted left by one column per accepted pixel.
  - The new column is the KY-1 stored pixels at the current x plus the incoming pixel at the bottom.
- Position counters x (0..IX-1) and y (0..IY-1) track the accepted pixel.
  - x wraps to 0 after IX-1, and y then increments.
  - After (IX-1, IY-1), both wrap to 0 and the next frame starts without reset.
  - Line-memory contents from the previous frame may remain; windows are only flagged when fully sourced from the current frame (y >= KY-1 rule).
- Window output rule: when pixel (x,y) is accepted with x >= KX-1 and y >= KY-1, on the next clock edge:
  - o_window_valid=1;
  - o_window holds pixels rows y-KY+1..y by columns x-KX+1..x;
  - o_if_x = x-KX+1 and o_if_y = y-KY+1.
  - Latency is 1 cycle from the accepting edge.
- o_window_valid is 0 in every other cycle, including cycles with i_in_valid=0.
  - o_window, o_if_x and o_if_y hold their last values when not valid.
- i_in_valid=0: counters, line memories and window registers are frozen. Gaps of any length are allowed between pixels.
- No window straddles a line wrap: the first KX-1 pixels of each line never produce a window.
- Windows per frame: (IX-KX+1)*(IY-KY+1); 576 at defaults.
- Reset (reset_n==1 at an edge), including mid-frame:
  - x=y=0; o_window_valid=0; o_window=0; o_if_x=0; o_if_y=0.
  - Window registers cleared. Line memory contents need not be cleared.
  - The next accepted pixel is treated as (0,0).
- i_in_valid is ignored while reset is asserted.

Optional Feature:
- Macro: LINE_BUFFER_FRAME_DONE_EN.
- When defined:
  - Adds output port o_frame_done (1 bit).
  - o_frame_done pulses 1 for one cycle on the edge after pixel (IX-1, IY-1) is accepted, coincident with the last o_window_valid.
  - o_frame_done resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then stream 784 pixels with value (i+1) mod 256, i_in_valid continuous. The first o_window_valid comes one cycle after pixel index 116 is accepted, with:
  - o_if_x=0, o_if_y=0;
  - rows 1-5, 29-33, 57-61, 85-89, 113-117.
- Same stream: count o_window_valid pulses, which must total 576. The last window has o_if_x=23, o_if_y=23, element (0,0)=156 and element (4,4)=16.
- Insert random i_in_valid=0 gaps into the stream. The window sequence and values must match the gap-free run, and there is no valid strobe during gaps.
- Check the line wrap. Windows at o_if_y=0 must run o_if_x=0..23 in consecutive valid cycles. No valid strobe follows any of the pixels at x=0..3 of line 5.
- Assert reset at pixel 300, then restart the stream from pixel 0. The first window again appears after 117 accepted pixels with o_if_x=0 and o_if_y=0, and all outputs are 0 during reset.
- With LINE_BUFFER_FRAME_DONE_EN, stream two back-to-back frames. o_frame_done pulses exactly twice, and the second frame's first window is at (0,0) with correct values.
